data_mem_responder: RTL and testbench

//   Memory-side responder for the core's load/store interface. It accepts one

---
 rtl/data_mem_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the core's load/store port. Accepts one request
//   at a time, runs it against an internal word-wide synchronous RAM and
//   returns sign/zero-extended load data or a store completion. Sub-word
//   stores are done as read-modify-write. Misaligned, out-of-range and
//   illegal-funct3 requests complete with an error and never touch the RAM.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   high while idle; transfer = req_valid & req_ready
//   req_addr    in   32  byte address
//   req_wren    in   1   1 = store, 0 = load
//   req_funct3  in   3   RV32I load/store funct3
//   req_wdata   in   32  store data (low byte/half for SB/SH)
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  load result; 0 for stores and errors
//   resp_err    out  1   request rejected (qualified by resp_valid)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wren,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Request fields captured at acceptance
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic          r_wren;
  logic [2:0]    r_f3;
  logic [15:0]   r_wbits;

  // RAM and its registered read port
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_ram_q;
  logic [31:0]   r_wword;

  // Registered response outputs
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [31:0]   r_resp_rdata;

  logic          w_accept;
  logic [31:0]   w_off;
  logic          w_oor;
  logic          w_f3_ok;
  logic          w_misal;
  logic          w_err;
  logic          w_is_sw;

  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [31:0]   w_merged;

  logic          w_valid_nxt;
  logic          w_err_nxt;
  logic [31:0]   w_rdata_nxt;

  logic          w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  // ---------------- request checks ----------------
  assign w_accept = req_valid & (r_state == IDLE);
  assign w_off    = req_addr - BASE_ADDR;
  assign w_oor    = ({2'b00, w_off[31:2]} >= 32'(DEPTH)) | (req_addr < BASE_ADDR);

  always_comb begin
    w_f3_ok = 1'b0;
    if (req_wren) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
        default:                w_f3_ok = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
        default:                                w_f3_ok = 1'b0;
      endcase
    end
  end

  assign w_misal = ((req_funct3[1:0] == 2'b01) & w_off[0]) |
                   ((req_funct3[1:0] == 2'b10) & (|w_off[1:0]));
  assign w_err   = w_oor | ~w_f3_ok | w_misal;
  assign w_is_sw = req_wren & (req_funct3 == 3'b010);

  // ---------------- load formatting / store merge ----------------
  always_comb begin
    w_byte = r_ram_q[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? r_ram_q[31:16] : r_ram_q[15:0];
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = r_ram_q;
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = '0;
    endcase
  end

  always_comb begin
    w_merged = r_ram_q;
    if (r_f3[1:0] == 2'b00) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wbits[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wbits;
    end
  end

  // ---------------- next state and next outputs ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err || w_is_sw) begin
            w_state_nxt = RESP;
            w_valid_nxt = 1'b1;
            w_err_nxt   = w_err;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      RD: begin
        if (r_wren) begin
          w_state_nxt = WR;
        end else begin
          w_state_nxt = RESP;
          w_valid_nxt = 1'b1;
          w_rdata_nxt = w_load_data;
        end
      end
      WR: begin
        w_state_nxt = RESP;
        w_valid_nxt = 1'b1;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- RAM port control ----------------
  // Write enable is also qualified by reset so that an access interrupted by
  // reset can never land on the RAM at the following edge.
  assign w_ram_we    = reset & ((w_accept & ~w_err & w_is_sw) | (r_state == WR));
  assign w_ram_re    = w_accept & ~w_err;
  assign w_ram_addr  = (r_state == WR) ? r_idx : w_off[AW+1:2];
  assign w_ram_wdata = (r_state == WR) ? r_wword : req_wdata;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_ram_addr];
    end
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_lane       <= '0;
      r_wren       <= 1'b0;
      r_f3         <= '0;
      r_wbits      <= '0;
      r_wword      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= w_valid_nxt;
      r_resp_err   <= w_err_nxt;
      r_resp_rdata <= w_rdata_nxt;
      if (w_accept) begin
        r_idx   <= w_off[AW+1:2];
        r_lane  <= w_off[1:0];
        r_wren  <= req_wren;
        r_f3    <= req_funct3;
        r_wbits <= req_wdata[15:0];
      end
      if (r_state == RD) begin
        r_wword <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wren;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wren   (req_wren),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Issues one request once the responder is idle and waits for its response.
  // lat = cycles from acceptance edge to the cycle showing resp_valid (99 = none).
  task automatic do_req(input logic wren, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output time t_resp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_wren   = wren;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rdata  = resp_rdata;
    err    = resp_err;
    t_resp = $time;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wren  = 1'b0;
    req_funct3 = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    #3 reset = 1'b0;
    #5;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sw_lw;
    int lat; logic [31:0] rd; logic er; time t;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, t);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL sw_latency got=%0d exp=1", lat); end
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, t);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    n_checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_store_byte;
    int lat; logic [31:0] rd; logic er; time t;
    do_req(1'b1, 3'b010, 32'h4, 32'h11223344, lat, rd, er, t);
    do_req(1'b1, 3'b000, 32'h5, 32'hFFFFFF80, lat, rd, er, t);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got=%0d exp=3", lat); end
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sb_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'h11228044) begin n_fail++; $display("FAIL sb_lw got=%h exp=11228044", rd); end
    do_req(1'b0, 3'b000, 32'h5, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || lat !== 2) begin n_fail++; $display("FAIL lb got=%h lat=%0d exp=ffffff80 lat=2", rd, lat); end
    do_req(1'b0, 3'b100, 32'h5, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got=%h exp=00000080", rd); end
    do_req(1'b0, 3'b100, 32'h6, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'h00000022) begin n_fail++; $display("FAIL lbu_lane2 got=%h exp=00000022", rd); end
  endtask

  task automatic test_store_half;
    int lat; logic [31:0] rd; logic er; time t;
    do_req(1'b1, 3'b001, 32'h6, 32'h0000BEEF, lat, rd, er, t);
    n_checks++;
    if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL sh_resp got lat=%0d err=%b exp lat=3 err=0", lat, er); end
    do_req(1'b0, 3'b001, 32'h6, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh got=%h exp=ffffbeef", rd); end
    do_req(1'b0, 3'b101, 32'h6, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu got=%h exp=0000beef", rd); end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hBEEF8044) begin n_fail++; $display("FAIL sh_lw got=%h exp=beef8044", rd); end
    do_req(1'b0, 3'b001, 32'h4, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hFFFF8044) begin n_fail++; $display("FAIL lh_low got=%h exp=ffff8044", rd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er; time t;
    logic        e_wren [5];
    logic [2:0]  e_f3   [5];
    logic [31:0] e_addr [5];
    e_wren[0] = 1'b0; e_f3[0] = 3'b001; e_addr[0] = 32'h3;
    e_wren[1] = 1'b1; e_f3[1] = 3'b010; e_addr[1] = 32'h2;
    e_wren[2] = 1'b1; e_f3[2] = 3'b011; e_addr[2] = 32'h0;
    e_wren[3] = 1'b1; e_f3[3] = 3'b010; e_addr[3] = 32'h1000;
    e_wren[4] = 1'b0; e_f3[4] = 3'b011; e_addr[4] = 32'h0;
    do_req(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, lat, rd, er, t);
    for (int i = 0; i < 5; i++) begin
      do_req(e_wren[i], e_f3[i], e_addr[i], 32'h12345678, lat, rd, er, t);
      n_checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0)
        begin n_fail++; $display("FAIL err_case%0d got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", i, lat, er, rd); end
    end
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_fail++; $display("FAIL err_mem_word0 got=%h err=%b exp=cafef00d err=0", rd, er); end
  endtask

  task automatic test_valid_held;
    int guard; int pulses;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_wren = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL held_rd got ready=%b valid=%b exp 0 0", req_ready, resp_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL held_resp got ready=%b valid=%b rdata=%h exp 0 1 deadbeef", req_ready, resp_valid, resp_rdata); end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL held_idle got ready=%b valid=%b exp 1 0", req_ready, resp_valid); end
    req_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL held_extra got pulses=%0d ready=%b exp 0 1", pulses, req_ready); end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] rd; logic er; time t; int guard; int pulses;
    do_req(1'b1, 3'b010, 32'h8, 32'hAABBCCDD, lat, rd, er, t);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_wren = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8; req_wdata = 32'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin n_fail++; $display("FAIL abort_outputs got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_resp got pulses=%0d exp 0", pulses); end
    do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, rd, er, t);
    n_checks++;
    if (rd !== 32'hAABBCCDD || lat !== 2) begin n_fail++; $display("FAIL abort_mem got=%h lat=%0d exp=aabbccdd lat=2", rd, lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic er; time t1, t2;
    do_req(1'b1, 3'b010, 32'h20, 32'h01020304, lat, rd, er, t1);
    do_req(1'b1, 3'b010, 32'h24, 32'h05060708, lat, rd, er, t2);
    n_checks++;
    if ((t2 - t1) !== 20) begin n_fail++; $display("FAIL b2b_sw got=%0t exp=20", t2 - t1); end
    do_req(1'b0, 3'b001, 32'h1, 32'h0, lat, rd, er, t1);
    do_req(1'b0, 3'b001, 32'h1, 32'h0, lat, rd, er, t2);
    n_checks++;
    if ((t2 - t1) !== 20 || er !== 1'b1) begin n_fail++; $display("FAIL b2b_err got=%0t err=%b exp=20 err=1", t2 - t1, er); end
    do_req(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er, t1);
    n_checks++;
    if (rd !== 32'h05060708) begin n_fail++; $display("FAIL b2b_readback got=%h exp=05060708", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_store_byte();
    test_store_half();
    test_errors();
    test_valid_held();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
